mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one WIDTH-bit shift-add multiplier (start/done datapath plus its controller) among N_REQ requesters.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the multiplier with a one-cycle start pulse, then waits for done.
- Returns the product to the winner with a one-cycle ack; a watchdog guards against a multiplier that never finishes.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- WIDTH, 8, operand width; product is 2*WIDTH.
- TIMEOUT, 32, max cycles in BUSY before abort (>= multiplier worst-case latency + 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  per-requester request level; held until own ack.
- req_a  in  N_REQ*WIDTH  packed multiplicands; slice i belongs to requester i.
- req_b  in  N_REQ*WIDTH  packed multipliers; slice i belongs to requester i.
- ack  out  N_REQ  one-hot, one-cycle completion pulse.
- rsp_product  out  2*WIDTH  result; valid while any ack bit is high.
- rsp_err  out  1  timeout flag; valid while any ack bit is high.
- rsp_id  out  clog2(N_REQ)  index of the serviced requester; valid while any ack bit is high.
- busy  out  1  high in every state except IDLE.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  WIDTH  multiplicand; held stable from START through RESP.
- mul_b  out  WIDTH  multiplier; held stable from START through RESP.
- mul_done  in  1  multiplier finished; level or pulse.
- mul_product  in  2*WIDTH  multiplier result; valid when mul_done is high.

Behaviour:
- All outputs are registered.
- Reset: state=IDLE, rr pointer=0, timer=0; every output 0 (ack, rsp_*, busy, mul_start, mul_a, mul_b).
- Reset asserted mid-operation aborts immediately with no ack. After reset, the multiplier controller is assumed to be reset as well.
- FSM has four states: IDLE, START, BUSY, RESP.
- IDLE:
  - If req != 0 at an edge, select winner = first set bit at or after pointer, wrapping.
  - Latch winner id, a slice, b slice into mul_a/mul_b.
  - Go to START.
  - mul_done is ignored in IDLE.
- START:
  - mul_start=1 for exactly this cycle; timer cleared.
  - Go to BUSY; mul_done is ignored in this state.
- BUSY:
  - timer increments each cycle.
  - If mul_done=1: capture mul_product, rsp_err=0, go to RESP.
  - Else if timer==TIMEOUT-1: rsp_product=0, rsp_err=1, go to RESP.
  - If mul_done and timeout occur in the same cycle, done wins (rsp_err=0).
- RESP:
  - ack[id]=1 for exactly one cycle; rsp_id=id.
  - pointer <= (id+1) mod N_REQ.
  - Go to IDLE.
- rsp_product, rsp_err and rsp_id hold their value until the next RESP.
- Latency:
  - mul_start is high in the cycle after req is sampled in IDLE.
  - ack is high in the cycle after mul_done is sampled.
  - Minimum req-to-ack = 3 cycles + multiplier latency.
- Requester rules:
  - Requester drops req in the cycle ack is seen.
  - A req still high in the next IDLE cycle counts as a new request, arbitrated behind the others by the rr pointer.
- Req dropped mid-operation: the operation still completes and ack is still pulsed.
- Operand changes on req_a/req_b after the grant are ignored.
- Throughput: one operation in flight; back-to-back requests pass through one IDLE cycle between operations.

Decomposition:
- Shared package mult_pkg:
  - State enum {IDLE, START, BUSY, RESP}, 2-bit encoding 00/01/10/11.
  - Default WIDTH, N_REQ and TIMEOUT constants.
  - Product-width constant 2*WIDTH.
- Sub-module rr_arbiter (combinational):
  - Inputs: req and pointer.
  - Outputs: one-hot grant, grant index, any_req.
  - Reused by other shared-resource controllers.

Test Plan:
- Single request, req[1] with a=13, b=11; stub multiplier with done after 9 cycles -> mul_start one cycle after req; ack=0010, rsp_product=143, rsp_err=0, rsp_id=1.
- All four req high at once from reset; a_i=i+1, b_i=10 -> service order 0,1,2,3; products 10,20,30,40; exactly one ack bit high per RESP.
- Fairness: req0 held continuously and req2 pulsed once after each of its acks -> grants alternate 0,2,0,2; neither starves.
- Timeout: mul_done never asserts -> ack after TIMEOUT cycles in BUSY with rsp_err=1 and rsp_product=0; pointer advances.
- Boundary: mul_done first asserted on timer==TIMEOUT-1 -> rsp_err=0 and the correct product; extreme operands 255*255 -> 65025.
- rst_n asserted mid-BUSY -> all outputs 0 asynchronously, no ack; after release the next grant starts from requester 0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and defaults for the shared-multiplier arbiter slice.
// Holds the controller state encoding and the default widths/timeout.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        BUSY  = 2'b10,
        RESP  = 2'b11
    } state_e;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_N_REQ   = 4;
    localparam int DEF_TIMEOUT = 32;
    localparam int DEF_PW      = 2 * DEF_WIDTH;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Bundle of requester-side and multiplier-side signals of the arbiter.
// slave: arbiter view; master: requesters + multiplier view.
interface mult_share_arbiter_if
    import mult_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int IW = $clog2(N_REQ);
    localparam int PW = prod_w(WIDTH);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       ack;
    logic [PW-1:0]          rsp_product;
    logic                   rsp_err;
    logic [IW-1:0]          rsp_id;
    logic                   busy;
    logic                   mul_start;
    logic [WIDTH-1:0]       mul_a;
    logic [WIDTH-1:0]       mul_b;
    logic                   mul_done;
    logic [PW-1:0]          mul_product;

    modport slave (
        input  req, req_a, req_b, mul_done, mul_product,
        output ack, rsp_product, rsp_err, rsp_id, busy,
        output mul_start, mul_a, mul_b
    );

    modport master (
        output req, req_a, req_b, mul_done, mul_product,
        input  ack, rsp_product, rsp_err, rsp_id, busy,
        input  mul_start, mul_a, mul_b
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at/after i_ptr.
// Ports: i_req, i_ptr in; o_grant (one-hot), o_idx, o_any out.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);

    always_comb begin : p_pick
        logic found;
        int   j;
        o_grant = '0;
        o_idx   = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            // Walk from the pointer upward, wrapping past N_REQ-1.
            j = (int'(i_ptr) + k) % N_REQ;
            if (!found && i_req[j]) begin
                found      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = IW'(j);
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one start/done multiplier among N_REQ requesters, round-robin.
// Ports: clk, rst_n (async low); bus (slave) carries req/rsp/mul signals.
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mult_share_arbiter_if.slave  bus
);

    localparam int IW = $clog2(N_REQ);
    localparam int PW = prod_w(WIDTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e           r_state;
    state_e           w_next;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_id;
    logic [TW-1:0]    r_timer;
    logic [N_REQ-1:0] r_ack;
    logic [PW-1:0]    r_rsp_product;
    logic             r_rsp_err;
    logic [IW-1:0]    r_rsp_id;
    logic             r_busy;
    logic             r_mul_start;
    logic [WIDTH-1:0] r_mul_a;
    logic [WIDTH-1:0] r_mul_b;

    logic [N_REQ-1:0] w_grant;
    logic [IW-1:0]    w_gidx;
    logic             w_any;
    logic             w_timeout;
    logic             w_finish;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    assign w_timeout = (r_timer == TW'(TIMEOUT - 1));
    assign w_finish  = bus.mul_done || w_timeout;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_next = START;
            START:   w_next = BUSY;
            BUSY:    if (w_finish) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_id          <= '0;
            r_timer       <= '0;
            r_ack         <= '0;
            r_rsp_product <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_id      <= '0;
            r_busy        <= 1'b0;
            r_mul_start   <= 1'b0;
            r_mul_a       <= '0;
            r_mul_b       <= '0;
        end else begin
            r_state     <= w_next;
            // Outputs are registered from the next state so they line up
            // with the state they describe.
            r_busy      <= (w_next != IDLE);
            r_mul_start <= (w_next == START);
            r_ack       <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_id    <= w_gidx;
                        r_mul_a <= bus.req_a[w_gidx*WIDTH +: WIDTH];
                        r_mul_b <= bus.req_b[w_gidx*WIDTH +: WIDTH];
                    end
                end
                START: r_timer <= '0;
                BUSY: begin
                    r_timer <= r_timer + 1'b1;
                    // Done has priority over a coincident timeout.
                    if (bus.mul_done) begin
                        r_rsp_product <= bus.mul_product;
                        r_rsp_err     <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_product <= '0;
                        r_rsp_err     <= 1'b1;
                    end
                    if (w_finish) begin
                        r_ack    <= N_REQ'(1) << r_id;
                        r_rsp_id <= r_id;
                    end
                end
                RESP: begin
                    r_ptr <= (r_id == IW'(N_REQ - 1)) ? '0 : r_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ack         = r_ack;
    assign bus.rsp_product = r_rsp_product;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_id      = r_rsp_id;
    assign bus.busy        = r_busy;
    assign bus.mul_start   = r_mul_start;
    assign bus.mul_a       = r_mul_a;
    assign bus.mul_b       = r_mul_b;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a stub latency multiplier.
// Ports: none; drives the interface master side and a stub multiplier.
module tb_mult_share_arbiter;
    import mult_pkg::*;

    logic clk;
    logic rst_n;
    int   nvec;
    int   nfail;
    int   lat;
    bit   never;
    int   cnt;
    logic [7:0] sa;
    logic [7:0] sb;

    mult_share_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

    mult_share_arbiter #(
        .N_REQ   (4),
        .WIDTH   (8),
        .TIMEOUT (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub multiplier: pulses done 'lat' cycles after seeing mul_start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= 0;
            sa              <= '0;
            sb              <= '0;
            bus.mul_done    <= 1'b0;
            bus.mul_product <= '0;
        end else begin
            bus.mul_done <= 1'b0;
            if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    bus.mul_done    <= 1'b1;
                    bus.mul_product <= {8'h00, sa} * {8'h00, sb};
                end
            end
            if (bus.mul_start && !never) begin
                cnt <= lat;
                sa  <= bus.mul_a;
                sb  <= bus.mul_b;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.ack == '0 && cyc < budget);
        check("ack_seen", 32'(|bus.ack), 1);
    endtask

    task automatic set_ops(input int i, input logic [7:0] a,
                           input logic [7:0] b);
        bus.req_a[i*8 +: 8] = a;
        bus.req_b[i*8 +: 8] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int cyc;
    int want;

    initial begin
        nvec    = 0;
        nfail   = 0;
        lat     = 9;
        never   = 1'b0;
        rst_n   = 1'b0;
        bus.req = '0;
        bus.req_a = '0;
        bus.req_b = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_start", 32'(bus.mul_start), 0);
        check("rst_mul_a", 32'(bus.mul_a), 0);
        check("rst_prod", 32'(bus.rsp_product), 0);
        check("rst_err", 32'(bus.rsp_err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request from requester 1: 13*11
        set_ops(1, 8'd13, 8'd11);
        bus.req = 4'b0010;
        @(negedge clk);
        check("s_start", 32'(bus.mul_start), 1);
        check("s_mul_a", 32'(bus.mul_a), 13);
        check("s_mul_b", 32'(bus.mul_b), 11);
        set_ops(1, 8'd99, 8'd99);
        @(negedge clk);
        check("s_start_pulse", 32'(bus.mul_start), 0);
        check("s_mul_a_hold", 32'(bus.mul_a), 13);
        wait_ack(40, cyc);
        check("s_latency", 32'(cyc + 2), 12);
        check("s_ack", 32'(bus.ack), 4'b0010);
        check("s_prod", 32'(bus.rsp_product), 143);
        check("s_err", 32'(bus.rsp_err), 0);
        check("s_id", 32'(bus.rsp_id), 1);
        bus.req = '0;
        @(negedge clk);
        check("s_ack_pulse", 32'(bus.ack), 0);
        check("s_idle", 32'(bus.busy), 0);
        check("s_prod_hold", 32'(bus.rsp_product), 143);

        // All four requesting out of reset
        lat = 2;
        for (int i = 0; i < 4; i++) set_ops(i, 8'(i + 1), 8'd10);
        bus.req = 4'b1111;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wait_ack(40, cyc);
            want = 10 * (k + 1);
            check("all_id", 32'(bus.rsp_id), k);
            check("all_ack", 32'(bus.ack), 32'(1) << k);
            check("all_prod", 32'(bus.rsp_product), want);
            bus.req[k] = 1'b0;
        end

        // Fairness: req0 held, req2 re-raised after each ack
        set_ops(0, 8'd3, 8'd7);
        set_ops(2, 8'd5, 8'd9);
        @(negedge clk);
        bus.req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            wait_ack(40, cyc);
            check("fair_id", 32'(bus.rsp_id), (k % 2 == 0) ? 0 : 2);
            check("fair_prod", 32'(bus.rsp_product),
                  (k % 2 == 0) ? 21 : 45);
            if (k == 3) begin
                bus.req = '0;
            end else if (k % 2 == 1) begin
                bus.req[2] = 1'b0;
                @(negedge clk);
                bus.req[2] = 1'b1;
            end
        end

        // Timeout: pointer sits at 3, only req1 -> wraps to 1
        never = 1'b1;
        @(negedge clk);
        set_ops(1, 8'd6, 8'd7);
        bus.req = 4'b0010;
        wait_ack(60, cyc);
        check("to_latency", 32'(cyc), 34);
        check("to_err", 32'(bus.rsp_err), 1);
        check("to_prod", 32'(bus.rsp_product), 0);
        check("to_id", 32'(bus.rsp_id), 1);
        bus.req = '0;

        // Done exactly at the timeout cycle; pointer now 2
        never = 1'b0;
        lat   = 31;
        @(negedge clk);
        set_ops(2, 8'd255, 8'd255);
        bus.req = 4'b0110;
        wait_ack(60, cyc);
        check("bd_latency", 32'(cyc), 34);
        check("bd_id", 32'(bus.rsp_id), 2);
        check("bd_err", 32'(bus.rsp_err), 0);
        check("bd_prod", 32'(bus.rsp_product), 65025);
        bus.req = '0;

        // Reset mid-BUSY: pointer is 3, req 1001 grants 3 first
        lat = 20;
        @(negedge clk);
        set_ops(0, 8'd4, 8'd5);
        set_ops(3, 8'd8, 8'd8);
        bus.req = 4'b1001;
        repeat (5) @(negedge clk);
        check("mr_busy", 32'(bus.busy), 1);
        check("mr_mul_a", 32'(bus.mul_a), 8);
        #2 rst_n = 1'b0;
        #1;
        check("mr_busy0", 32'(bus.busy), 0);
        check("mr_ack0", 32'(bus.ack), 0);
        check("mr_mul_a0", 32'(bus.mul_a), 0);
        check("mr_prod0", 32'(bus.rsp_product), 0);
        check("mr_id0", 32'(bus.rsp_id), 0);
        @(negedge clk);
        check("mr_ack_hold", 32'(bus.ack), 0);
        rst_n = 1'b1;
        wait_ack(40, cyc);
        check("mr_id", 32'(bus.rsp_id), 0);
        check("mr_prod", 32'(bus.rsp_product), 20);
        bus.req = '0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
